alct_daq_readout: RTL and testbench

- Downstream consumer of the 30-bit L1A FIFO.
- Pops one L1A entry at a time and fetches the requested time bins from the raw-hit buffer (synchronous BRAM read port).
- Emits a contiguous 16-bit DAQ frame: header, raw data, checksum, trailer.
- Sits between the L1A FIFO and the DAQ serializer/link.

---
 rtl/alct_daq_if.sv | 28 ++
 rtl/alct_daq_readout.sv | 149 ++++++++++++++
 tb/tb_alct_daq_readout.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alct_daq_if.sv
// ALCT DAQ readout bus: L1A FIFO pop side, raw-hit buffer read port and
// the outgoing 16-bit DAQ frame stream.
interface alct_daq_if #(
   parameter int RAW_AW = 11
);
   logic [29:0]       fifo_dout;
   logic              fifo_empty;
   logic              fifo_ren;
   logic [RAW_AW-1:0] raw_addr;
   logic [15:0]       raw_data;
   logic              daq_en;
   logic [15:0]       daq_data;
   logic              daq_valid;
   logic              daq_first;
   logic              daq_last;

   // Readout engine side.
   modport master (
      input  fifo_dout, fifo_empty, raw_data, daq_en,
      output fifo_ren, raw_addr, daq_data, daq_valid, daq_first, daq_last
   );

   // FIFO / raw buffer / link side.
   modport slave (
      output fifo_dout, fifo_empty, raw_data, daq_en,
      input  fifo_ren, raw_addr, daq_data, daq_valid, daq_first, daq_last
   );
endinterface

// File: rtl/alct_daq_readout.sv
// ALCT DAQ readout: pops one L1A entry, walks the requested time bins of the
// raw-hit buffer and emits header, raw data, checksum and trailer words.
module alct_daq_readout #(
   parameter int WORDS_PER_BIN = 6,
   parameter int RAW_AW        = 11
) (
   input  logic        clk,
   input  logic        reset,
   alct_daq_if.master  bus,
   output logic        busy,
   output logic [11:0] frame_cnt
);

   typedef enum logic [2:0] {IDLE, LATCH, HDR0, HDR1, DATA, CHK, TRL} state_t;

   state_t      state_q, state_d;

   logic [11:0] bxn_q;
   logic [3:0]  l1a_q;
   logic        match_q;
   logic [4:0]  tbins_q;
   logic [8:0]  n_words_q;
   logic [8:0]  data_idx_q;
   logic [7:0]  bin_q;
   logic [2:0]  word_q;
   logic [15:0] chk_q;
   logic [15:0] daq_data_q;
   logic        daq_valid_q, daq_first_q, daq_last_q;

   logic [15:0] h0_word, h1_word, trl_word;
   logic [8:0]  n_words_calc;

   assign h0_word      = {4'hD, bxn_q};
   assign h1_word      = {4'hA, l1a_q, match_q, 2'b00, tbins_q};
   assign trl_word     = {4'hE, 12'(n_words_q) + 12'd4};
   assign n_words_calc = (9'(bus.fifo_dout[4:0]) + 9'd1) * 9'(WORDS_PER_BIN);

   assign bus.raw_addr  = RAW_AW'({bin_q, word_q});
   assign bus.daq_data  = daq_data_q;
   assign bus.daq_valid = daq_valid_q;
   assign bus.daq_first = daq_first_q;
   assign bus.daq_last  = daq_last_q;
   assign busy          = (state_q != IDLE);

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode and the combinational pop strobe (only ever in IDLE).
   always_comb begin
      // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
      state_d      = state_q;
      bus.fifo_ren = 1'b0;
      case (state_q)
         IDLE: if (!bus.fifo_empty && bus.daq_en) begin
            bus.fifo_ren = 1'b1;
            state_d      = LATCH;
         end
         LATCH: state_d = HDR0;
         HDR0:  state_d = HDR1;
         HDR1:  state_d = DATA;
         DATA:  if (data_idx_q == n_words_q - 9'd1) state_d = CHK;
         CHK:   state_d = TRL;
         TRL:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Entry latch, raw address walk, checksum and registered frame output.
   always_ff @(posedge clk) begin
      if (reset) begin
         bxn_q       <= '0;
         l1a_q       <= '0;
         match_q     <= 1'b0;
         tbins_q     <= '0;
         n_words_q   <= '0;
         data_idx_q  <= '0;
         bin_q       <= '0;
         word_q      <= '0;
         chk_q       <= '0;
         daq_data_q  <= '0;
         daq_valid_q <= 1'b0;
         daq_first_q <= 1'b0;
         daq_last_q  <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         daq_valid_q <= 1'b0;
         daq_first_q <= 1'b0;
         daq_last_q  <= 1'b0;

         // Address advances from HDR1 onward so raw_data for word k lands
         // exactly in the cycle word k is registered.
         if (state_q == HDR1 || state_q == DATA) begin
            if (word_q == 3'(WORDS_PER_BIN - 1)) begin
               word_q <= '0;
               bin_q  <= bin_q + 8'd1;
            end else begin
               word_q <= word_q + 3'd1;
            end
         end

         case (state_q)
            IDLE: if (bus.fifo_ren) chk_q <= '0;
            LATCH: begin
               bxn_q      <= bus.fifo_dout[29:18];
               l1a_q      <= bus.fifo_dout[17:14];
               match_q    <= bus.fifo_dout[5];
               tbins_q    <= bus.fifo_dout[4:0];
               n_words_q  <= n_words_calc;
               data_idx_q <= '0;
               bin_q      <= bus.fifo_dout[13:6];
               word_q     <= '0;
            end
            HDR0: begin
               daq_data_q  <= h0_word;
               daq_valid_q <= 1'b1;
               daq_first_q <= 1'b1;
               chk_q       <= chk_q ^ h0_word;
            end
            HDR1: begin
               daq_data_q  <= h1_word;
               daq_valid_q <= 1'b1;
               chk_q       <= chk_q ^ h1_word;
            end
            DATA: begin
               daq_data_q  <= bus.raw_data;
               daq_valid_q <= 1'b1;
               chk_q       <= chk_q ^ bus.raw_data;
               data_idx_q  <= data_idx_q + 9'd1;
            end
            CHK: begin
               daq_data_q  <= chk_q;
               daq_valid_q <= 1'b1;
            end
            TRL: begin
               daq_data_q  <= trl_word;
               daq_valid_q <= 1'b1;
               daq_last_q  <= 1'b1;
               frame_cnt   <= frame_cnt + 12'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alct_daq_readout.sv
// Directed bench for alct_daq_readout: FIFO and raw-buffer models, per-cycle
// frame checking against expected words built from the entry fields.
module tb_alct_daq_readout;

   localparam int WPB = 6;

   logic        clk = 1'b0;
   logic        reset;
   logic        busy;
   logic [11:0] frame_cnt;

   int total = 0;
   int bad   = 0;
   int exp_frames = 0;

   logic [29:0] fifo_mem [16];
   int          wr_ptr = 0;
   int          rd_ptr = 0;

   alct_daq_if #(.RAW_AW(11)) bus ();

   alct_daq_readout #(.WORDS_PER_BIN(WPB), .RAW_AW(11)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   // Raw buffer contents are a function of the address; synchronous read.
   function automatic logic [15:0] raw_word(input logic [10:0] a);
      return {a[4:0], a};
   endfunction

   function automatic logic [10:0] exp_addr(input logic [7:0] sb, input int j);
      logic [7:0] b;
      logic [2:0] w;
      b = sb + 8'(j / WPB);
      w = 3'(j % WPB);
      return {b, w};
   endfunction

   function automatic logic [29:0] mk_entry(input logic [11:0] bxn, input logic [3:0] l1a,
                                            input logic [7:0] sb, input logic m, input logic [4:0] tb);
      return {bxn, l1a, sb, m, tb};
   endfunction

   assign bus.fifo_empty = (wr_ptr == rd_ptr);

   // FIFO model: data appears the cycle after the pop strobe.
   always @(posedge clk) begin
      if (bus.fifo_ren && (wr_ptr != rd_ptr)) begin
         bus.fifo_dout <= fifo_mem[rd_ptr % 16];
         rd_ptr        <= rd_ptr + 1;
      end
   end

   always @(posedge clk) bus.raw_data <= raw_word(bus.raw_addr);

   task automatic push(input logic [29:0] e);
      fifo_mem[wr_ptr % 16] = e;
      wr_ptr = wr_ptr + 1;
      #1;
   endtask

   // Waits for the pop, then checks every bus cycle up to the trailer.
   task automatic expect_frame(input logic [29:0] e, input logic chk_next_pop);
      int          n;
      int          waited;
      logic [15:0] h0, h1, chk, trl, exp_d;
      logic        exp_busy;
      n   = (int'(e[4:0]) + 1) * WPB;
      h0  = {4'hD, e[29:18]};
      h1  = {4'hA, e[17:14], e[5], 2'b00, e[4:0]};
      trl = {4'hE, 12'(n + 4)};
      chk = h0 ^ h1;
      for (int j = 0; j < n; j++) chk = chk ^ raw_word(exp_addr(e[13:6], j));
      waited = 0;
      while (bus.fifo_ren !== 1'b1 && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      total++;
      if (bus.fifo_ren !== 1'b1) begin
         bad++;
         $display("FAIL pop_wait: fifo_ren=%b after %0d cycles, want 1", bus.fifo_ren, waited);
         return;
      end
      exp_frames = (exp_frames + 1) % 4096;
      for (int k = 1; k <= 6 + n; k++) begin
         @(negedge clk);
         exp_busy = (k <= 5 + n);
         total++;
         if (bus.daq_valid !== (k >= 3)) begin
            bad++;
            $display("FAIL valid k=%0d: got %b want %b", k, bus.daq_valid, (k >= 3));
         end
         total++;
         if (busy !== exp_busy) begin
            bad++;
            $display("FAIL busy k=%0d: got %b want %b", k, busy, exp_busy);
         end
         if (k < 6 + n) begin
            total++;
            if (bus.fifo_ren !== 1'b0) begin
               bad++;
               $display("FAIL ren_in_frame k=%0d: got %b want 0", k, bus.fifo_ren);
            end
         end else if (chk_next_pop) begin
            total++;
            if (bus.fifo_ren !== 1'b1) begin
               bad++;
               $display("FAIL next_pop k=%0d: got %b want 1", k, bus.fifo_ren);
            end
         end
         if (k >= 3 && k < 3 + n) begin
            total++;
            if (bus.raw_addr !== exp_addr(e[13:6], k - 3)) begin
               bad++;
               $display("FAIL raw_addr k=%0d: got %h want %h", k, bus.raw_addr, exp_addr(e[13:6], k - 3));
            end
         end
         if (k >= 3) begin
            if (k == 3)          exp_d = h0;
            else if (k == 4)     exp_d = h1;
            else if (k < 5 + n)  exp_d = raw_word(exp_addr(e[13:6], k - 5));
            else if (k == 5 + n) exp_d = chk;
            else                 exp_d = trl;
            total++;
            if (bus.daq_data !== exp_d) begin
               bad++;
               $display("FAIL daq_data k=%0d: got %h want %h", k, bus.daq_data, exp_d);
            end
            total++;
            if (bus.daq_first !== (k == 3) || bus.daq_last !== (k == 6 + n)) begin
               bad++;
               $display("FAIL first_last k=%0d: got %b%b want %b%b", k, bus.daq_first, bus.daq_last,
                        (k == 3), (k == 6 + n));
            end
         end
         if (k == 6 + n) begin
            total++;
            if (frame_cnt !== 12'(exp_frames)) begin
               bad++;
               $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, exp_frames);
            end
         end
      end
   endtask

   task automatic expect_idle(input string tag);
      @(negedge clk);
      total++;
      if (bus.daq_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s: valid=%b busy=%b want 0 0", tag, bus.daq_valid, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.daq_en = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      total++;
      if (bus.daq_valid !== 1'b0 || bus.daq_first !== 1'b0 || bus.daq_last !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags: v/f/l=%b%b%b want 000", bus.daq_valid, bus.daq_first, bus.daq_last);
      end
      total++;
      if (busy !== 1'b0 || bus.fifo_ren !== 1'b0) begin
         bad++;
         $display("FAIL reset_busy_ren: %b%b want 00", busy, bus.fifo_ren);
      end
      total++;
      if (bus.daq_data !== 16'h0 || bus.raw_addr !== 11'h0 || frame_cnt !== 12'h0) begin
         bad++;
         $display("FAIL reset_regs: data=%h addr=%h cnt=%h want 0 0 0", bus.daq_data, bus.raw_addr, frame_cnt);
      end
   endtask

   task automatic test_single_frame();
      logic [29:0] e;
      e = mk_entry(12'h123, 4'h5, 8'h10, 1'b1, 5'd1);
      bus.daq_en = 1'b1;
      push(e);
      expect_frame(e, 1'b0);
      expect_idle("single_after");
   endtask

   task automatic test_bin_wrap();
      logic [29:0] e;
      e = mk_entry(12'hABC, 4'h3, 8'hFF, 1'b0, 5'd1);
      push(e);
      expect_frame(e, 1'b0);
      expect_idle("wrap_after");
   endtask

   // Pop lands on the IDLE cycle right after TRL; the bus then sits idle
   // until the next H0 (checked by the valid expectations at k=1,2).
   task automatic test_back_to_back();
      logic [29:0] e1, e2;
      e1 = mk_entry(12'h001, 4'h1, 8'h20, 1'b1, 5'd0);
      e2 = mk_entry(12'hFFF, 4'hF, 8'h40, 1'b0, 5'd2);
      push(e1);
      push(e2);
      expect_frame(e1, 1'b1);
      expect_frame(e2, 1'b0);
      expect_idle("b2b_after");
   endtask

   task automatic test_max_length();
      logic [29:0] e;
      e = mk_entry(12'h5A5, 4'h9, 8'hC0, 1'b1, 5'd31);
      push(e);
      expect_frame(e, 1'b0);
      expect_idle("max_after");
   endtask

   task automatic test_inhibit();
      logic [29:0] e;
      e = mk_entry(12'h777, 4'h7, 8'h01, 1'b0, 5'd0);
      bus.daq_en = 1'b0;
      push(e);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (bus.fifo_ren !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL inhibit cycle %0d: ren=%b busy=%b want 0 0", i, bus.fifo_ren, busy);
         end
      end
      bus.daq_en = 1'b1;
      #1;
      expect_frame(e, 1'b0);
      expect_idle("inhibit_after");
   endtask

   task automatic test_reset_mid_frame();
      logic [29:0] e, e2;
      int waited;
      e  = mk_entry(12'h246, 4'h2, 8'h30, 1'b1, 5'd3);
      e2 = mk_entry(12'h135, 4'h4, 8'h50, 1'b0, 5'd0);
      push(e);
      waited = 0;
      while (bus.fifo_ren !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      repeat (8) @(negedge clk);
      total++;
      if (bus.daq_data !== raw_word(exp_addr(8'h30, 3)) || bus.daq_valid !== 1'b1) begin
         bad++;
         $display("FAIL mid_word3: data=%h valid=%b want %h 1", bus.daq_data, bus.daq_valid,
                  raw_word(exp_addr(8'h30, 3)));
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_frames = 0;
      total++;
      if (bus.daq_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 12'h0) begin
         bad++;
         $display("FAIL mid_reset: valid=%b busy=%b cnt=%0d want 0 0 0", bus.daq_valid, busy, frame_cnt);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         total++;
         if (bus.daq_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_no_trl cycle %0d: valid=%b data=%h want valid 0", i, bus.daq_valid, bus.daq_data);
         end
      end
      push(e2);
      expect_frame(e2, 1'b0);
      expect_idle("mid_after");
   endtask

   initial begin
      reset = 1'b1;
      bus.daq_en = 1'b0;
      test_reset();
      test_single_frame();
      test_bin_wrap();
      test_back_to_back();
      test_max_length();
      test_inhibit();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
